// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage interlock controller:
// default write-back distance, FSM encoding, NOP constant, busy helper.
package pipeline_hazard_ctrl_pkg;

    localparam int WB_DIST_DEF = 3;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Canonical NOP (ADDI R0,R0,0) loaded into a squashed ID/EX slot.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // A counter of 1 means the write lands in the register file this
    // cycle (write-first), so a reader may proceed. Only >1 blocks.
    function automatic logic reg_busy(input logic [1:0] cnt);
        return cnt > 2'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: 31 x 2-bit countdowns (R0 untracked).
// Ports: clk/rst, i_set_en/i_set_reg load a counter, i_rd_a/i_rd_b
// read ports -> o_busy_a/o_busy_b, o_all_clear when nothing blocks.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_DIST = WB_DIST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_set_en,
    input  logic [4:0] i_set_reg,
    input  logic [4:0] i_rd_a,
    input  logic [4:0] i_rd_b,
    output logic       o_busy_a,
    output logic       o_busy_b,
    output logic       o_all_clear
);

    localparam logic [1:0] W_SET = 2'(WB_DIST);

    logic [1:0] r_cnt [32];
    logic       w_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (i_set_en && i_set_reg == 5'(i)) begin
                    r_cnt[i] <= W_SET;
                end else if (r_cnt[i] != 2'd0) begin
                    r_cnt[i] <= r_cnt[i] - 2'd1;
                end
            end
        end
    end

    assign o_busy_a = (i_rd_a != 5'd0) && reg_busy(r_cnt[i_rd_a]);
    assign o_busy_b = (i_rd_b != 5'd0) && reg_busy(r_cnt[i_rd_b]);

    // Clear once every counter will be zero after this cycle's decrement.
    always_comb begin
        w_clear = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (reg_busy(r_cnt[i])) begin
                w_clear = 1'b0;
            end
        end
    end

    assign o_all_clear = w_clear;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock controller beside ID: RAW stalls, branch squash, HLT drain.
// Ports: clk1/rst, ID instruction fields, ex_br_taken -> stall, bubble,
// flush, halted (sticky), stall_cnt (saturating hazard-stall count).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_DIST = WB_DIST_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_reg,
    input  logic             id_halt,
    input  logic             ex_br_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_busy_rs;
    logic w_busy_rt;
    logic w_all_clear;
    logic w_haz;
    logic w_run;
    logic w_issue;
    logic w_set;
    logic w_stall_evt;

    assign w_run   = (r_state == ST_RUN);
    assign w_haz   = id_valid & ((id_uses_rs & w_busy_rs) |
                                 (id_uses_rt & w_busy_rt));
    assign w_issue = id_valid & ~w_haz & ~ex_br_taken & w_run;
    // HLT never reserves a destination.
    assign w_set   = w_issue & id_wr_en & ~id_halt &
                     (id_wr_reg != 5'd0);
    assign w_stall_evt = w_run & w_haz & ~ex_br_taken;

    hazard_scoreboard #(
        .WB_DIST (WB_DIST)
    ) u_sb (
        .clk         (clk1),
        .rst         (rst),
        .i_set_en    (w_set),
        .i_set_reg   (id_wr_reg),
        .i_rd_a      (id_rs),
        .i_rd_b      (id_rt),
        .o_busy_a    (w_busy_rs),
        .o_busy_b    (w_busy_rt),
        .o_all_clear (w_all_clear)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_issue && id_halt) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_all_clear) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // A taken branch beats a hazard: the squashed instruction is not held.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        halted = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                flush  = ex_br_taken;
                bubble = w_haz | ex_br_taken;
                stall  = w_haz & ~ex_br_taken;
            end
            ST_DRAIN: begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
            ST_HALTED: begin
                stall  = 1'b1;
                bubble = 1'b1;
                halted = 1'b1;
            end
            default: begin
                stall  = 1'b0;
            end
        endcase
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-based
// readiness model checked every cycle plus literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int WB  = 3;
    localparam int CW  = 3;
    localparam int SAT = 7;

    localparam int MRUN   = 0;
    localparam int MDRAIN = 1;
    localparam int MHALT  = 2;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_wr_en;
    logic [4:0]    id_wr_reg;
    logic          id_halt;
    logic          ex_br_taken;
    logic          stall;
    logic          bubble;
    logic          flush;
    logic          halted;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(
        .WB_DIST (WB),
        .CNT_W   (CW)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_halt     (id_halt),
        .ex_br_taken (ex_br_taken),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    // Model: each register has the cycle at which it becomes readable.
    int ready [32];
    int mstate = MRUN;
    int mstall = 0;
    int cyc    = 0;

    function automatic bit m_haz();
        bit h = 0;
        if (id_valid) begin
            if (id_uses_rs && id_rs != 0 && cyc < ready[id_rs]) h = 1;
            if (id_uses_rt && id_rt != 0 && cyc < ready[id_rt]) h = 1;
        end
        return h;
    endfunction

    always @(posedge clk1 or posedge rst) begin
        bit h;
        bit done;
        if (rst) begin
            for (int i = 0; i < 32; i++) ready[i] = 0;
            mstate = MRUN;
            mstall = 0;
        end else begin
            h = m_haz();
            if (mstate == MRUN) begin
                if (h && !ex_br_taken && mstall < SAT) mstall++;
                if (id_valid && !h && !ex_br_taken) begin
                    if (id_halt) mstate = MDRAIN;
                    else if (id_wr_en && id_wr_reg != 0)
                        ready[id_wr_reg] = cyc + WB;
                end
            end else if (mstate == MDRAIN) begin
                done = 1;
                for (int i = 1; i < 32; i++)
                    if (ready[i] > cyc) done = 0;
                if (done) mstate = MHALT;
            end
            cyc++;
        end
    end

    always @(negedge clk1) begin
        bit h;
        int es, eb, ef, eh;
        h = m_haz();
        es = 0; eb = 0; ef = 0; eh = 0;
        if (mstate == MRUN) begin
            ef = int'(ex_br_taken);
            eb = int'(h | ex_br_taken);
            es = int'(h & ~ex_br_taken);
        end else begin
            es = 1;
            eb = 1;
            eh = (mstate == MHALT) ? 1 : 0;
        end
        check("m_stall", int'(stall), es);
        check("m_bubble", int'(bubble), eb);
        check("m_flush", int'(flush), ef);
        check("m_halted", int'(halted), eh);
        check("m_stall_cnt", int'(stall_cnt), mstall);
    end

    task automatic set_in(input bit v, input int rs, input int rt,
                          input bit urs, input bit urt, input bit wr,
                          input int wreg, input bit hl, input bit br);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_wr_en    = wr;
        id_wr_reg   = 5'(wreg);
        id_halt     = hl;
        ex_br_taken = br;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    // Present an instruction until it issues; return stall cycles seen.
    task automatic send(input int rs, input int rt, input bit urs,
                        input bit urt, input bit wr, input int wreg,
                        input bit hl, output int stalls);
        bit done = 0;
        set_in(1, rs, rt, urs, urt, wr, wreg, hl, 0);
        stalls = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk1);
            if (stall) stalls++;
            else done = 1;
            @(posedge clk1);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=%0d want=issue", stalls);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk1);
        check("rst_stall", int'(stall), 0);
        check("rst_bubble", int'(bubble), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_cnt", int'(stall_cnt), 0);
        @(posedge clk1);
        #1;
        rst = 1'b0;
        idle(1);

        // ADDI R2 then ADD R3=R2+R1
        send(1, 0, 1, 0, 1, 2, 0, s);
        check("t1_prod", s, 0);
        send(2, 1, 1, 1, 1, 3, 0, s);
        check("t1_cons_stalls", s, 2);
        check("t1_cnt", int'(stall_cnt), 2);
        idle(4);

        // producer R5, two unrelated, consumer of R5
        send(1, 0, 1, 0, 1, 5, 0, s);
        check("t2_a", s, 0);
        send(1, 0, 1, 0, 1, 6, 0, s);
        check("t2_b", s, 0);
        send(1, 1, 1, 1, 1, 8, 0, s);
        check("t2_c", s, 0);
        send(5, 0, 1, 0, 1, 11, 0, s);
        check("t2_cons", s, 0);
        check("t2_cnt", int'(stall_cnt), 2);
        idle(4);

        // branch squashes a waiting consumer; R4 keeps counting
        send(1, 0, 1, 0, 1, 4, 0, s);
        set_in(1, 4, 0, 1, 0, 1, 12, 0, 1);
        @(negedge clk1);
        check("t3_flush", int'(flush), 1);
        check("t3_bubble", int'(bubble), 1);
        check("t3_stall", int'(stall), 0);
        @(posedge clk1);
        #1;
        send(4, 0, 1, 0, 1, 12, 0, s);
        check("t3_refetch", s, 1);
        check("t3_cnt", int'(stall_cnt), 3);
        idle(4);

        // R0 never tracked; back-to-back writes to R7 reload
        send(1, 0, 1, 0, 1, 0, 0, s);
        send(0, 0, 1, 1, 1, 13, 0, s);
        check("t4_r0", s, 0);
        send(1, 0, 1, 0, 1, 7, 0, s);
        send(1, 0, 1, 0, 1, 7, 0, s);
        send(0, 7, 0, 1, 1, 14, 0, s);
        check("t4_r7", s, 2);
        check("t4_cnt", int'(stall_cnt), 5);
        idle(4);

        // HLT with R9 in flight: two DRAIN cycles, then halted
        send(1, 0, 1, 0, 1, 9, 0, s);
        send(0, 0, 0, 0, 0, 0, 1, s);
        check("t5_hlt", s, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk1);
        check("t5_d1_halted", int'(halted), 0);
        check("t5_d1_stall", int'(stall), 1);
        @(posedge clk1);
        #1;
        @(negedge clk1);
        check("t5_d2_halted", int'(halted), 0);
        @(posedge clk1);
        #1;
        @(negedge clk1);
        check("t5_halted", int'(halted), 1);
        @(posedge clk1);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk1);
        check("t5_br_halted", int'(halted), 1);
        check("t5_br_flush", int'(flush), 0);
        @(posedge clk1);
        #1;
        idle(1);
        @(negedge clk1);
        check("t5_sticky", int'(halted), 1);

        // async reset while draining
        @(posedge clk1);
        #1;
        rst = 1'b1;
        @(posedge clk1);
        #1;
        rst = 1'b0;
        send(1, 0, 1, 0, 1, 9, 0, s);
        send(9, 0, 1, 0, 1, 15, 0, s);
        check("t6_pre_stalls", s, 2);
        send(1, 0, 1, 0, 1, 9, 0, s);
        send(0, 0, 0, 0, 0, 0, 1, s);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t6_drain", int'(stall), 1);
        rst = 1'b1;
        #1;
        check("t6_stall", int'(stall), 0);
        check("t6_bubble", int'(bubble), 0);
        check("t6_flush", int'(flush), 0);
        check("t6_halted", int'(halted), 0);
        check("t6_cnt", int'(stall_cnt), 0);
        #1;
        rst = 1'b0;
        @(posedge clk1);
        #1;
        send(9, 0, 1, 0, 1, 16, 0, s);
        check("t6_r9_free", s, 0);
        idle(4);

        // saturation of the 3-bit stall counter
        for (int k = 0; k < 4; k++) begin
            send(1, 0, 1, 0, 1, 10, 0, s);
            send(10, 0, 1, 0, 1, 17, 0, s);
            check("t7_stalls", s, 2);
        end
        check("t7_sat", int'(stall_cnt), SAT);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
